// File: rtl/audio_axi_write_master_if.sv
// AXI-lite style write channel (AW, W, B) between the audio control master and the register slave.
interface audio_axi_write_master_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 7
);
    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic              WVALID;
    logic              WREADY;
    logic              BVALID;
    logic              BREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WVALID, BREADY,
        input  AWREADY, WREADY, BVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WVALID, BREADY,
        output AWREADY, WREADY, BVALID
    );
endinterface

// File: rtl/audio_axi_write_master.sv
// Replays queued {addr,data} control commands as single AW+W+B write transactions.
// Optional per-transaction abort timer: define AUDIO_WR_TIMEOUT_EN.
module audio_axi_write_master #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 7,
    parameter int unsigned FIFO_DEPTH  = 4
`ifdef AUDIO_WR_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDR_W-1:0]           cmd_addr,
    input  logic [DATA_W-1:0]           cmd_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    audio_axi_write_master_if.master    axi,
    output logic                        wr_done,
    output logic                        wr_timeout
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_t;

    cmd_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              cmd_ready_q;
    logic              push, pop;

    state_t            state_q, state_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef AUDIO_WR_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              to_q, to_d;
`endif

    assign push = cmd_valid && cmd_ready_q;

    // Command storage; no reset needed, occupancy is tracked by count_q
    always_ff @(posedge ACLK) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_addr, cmd_data};
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + LVL_W'(1);
        else if (!push && pop) count_d = count_q - LVL_W'(1);
    end

    // cmd_ready follows the post-update level so it is registered yet never overfills
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_d;
            cmd_ready_q <= (count_d != LVL_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

`ifdef AUDIO_WR_TIMEOUT_EN
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            to_cnt_q <= '0;
            to_q     <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_q     <= to_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        pop       = 1'b0;
`ifdef AUDIO_WR_TIMEOUT_EN
        to_d      = 1'b0;
        to_cnt_d  = '0;
`endif
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    awaddr_d  = mem_q[rd_ptr_q].addr;
                    wdata_d   = mem_q[rd_ptr_q].data;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ADDR_DATA;
                end
            end
            // AW and W retire independently; B is only accepted once both are gone
            ADDR_DATA: begin
                if (axi.AWREADY) awvalid_d = 1'b0;
                if (axi.WREADY)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (axi.BVALID) begin
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AUDIO_WR_TIMEOUT_EN
        // A completion landing on the limit cycle has already returned to IDLE and wins
        if (state_q != IDLE) to_cnt_d = to_cnt_q + TO_W'(1);
        if (state_q != IDLE && state_d != IDLE && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            state_d   = IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            to_d      = 1'b1;
        end
`endif
    end

    assign cmd_ready   = cmd_ready_q;
    assign fifo_level  = count_q;
    assign axi.AWADDR  = awaddr_q;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = bready_q;
    assign wr_done     = done_q;
`ifdef AUDIO_WR_TIMEOUT_EN
    assign wr_timeout  = to_q;
`else
    assign wr_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_audio_axi_write_master.sv
// Bench for audio_axi_write_master: directed scenarios plus a randomized run against a queue model.
module tb_audio_axi_write_master;
    logic       ACLK = 1'b0;
    logic       ARESETn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_addr;
    logic [6:0] cmd_data;
    logic [2:0] fifo_level;
    logic       wr_done;
    logic       wr_timeout;
    int         n_tests = 0;
    int         n_fail  = 0;

    audio_axi_write_master_if #(.ADDR_W(4), .DATA_W(7)) axi ();

    audio_axi_write_master #(
        .ADDR_W(4), .DATA_W(7), .FIFO_DEPTH(4)
`ifdef AUDIO_WR_TIMEOUT_EN
       ,.TIMEOUT_CYC(8)
`endif
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .fifo_level(fifo_level), .axi(axi),
        .wr_done(wr_done), .wr_timeout(wr_timeout)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic hard_reset(input logic bv);
        cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = bv;
        ARESETn = 1'b0;
        #2;
        ARESETn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0;
        ARESETn = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        n_tests++;
        if ({axi.AWVALID, axi.WVALID, axi.BREADY, wr_done, wr_timeout} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 00000", {axi.AWVALID, axi.WVALID, axi.BREADY, wr_done, wr_timeout});
        end
        n_tests++;
        if ({axi.AWADDR, axi.WDATA, fifo_level} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_data got addr=%h data=%h lvl=%0d exp all 0", axi.AWADDR, axi.WDATA, fifo_level);
        end
        ARESETn = 1'b1;
        tick();
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_single();
        int dones = 0;
        hard_reset(1'b1);
        axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
        cmd_addr = 4'h9; cmd_data = 7'h2A; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n_tests++;
        if ({axi.AWVALID, fifo_level} !== {1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL single_queued got awv=%b lvl=%0d exp awv=0 lvl=1", axi.AWVALID, fifo_level);
        end
        tick();
        n_tests++;
        if ({axi.AWVALID, axi.WVALID, axi.AWADDR, axi.WDATA, fifo_level} !== {1'b1, 1'b1, 4'h9, 7'h2A, 3'd0}) begin
            n_fail++;
            $display("FAIL single_launch got awv=%b wv=%b addr=%h data=%h lvl=%0d exp 1 1 9 2a 0",
                     axi.AWVALID, axi.WVALID, axi.AWADDR, axi.WDATA, fifo_level);
        end
        repeat (6) begin
            tick();
            dones += int'(wr_done);
        end
        n_tests++;
        if (dones != 1 || fifo_level !== 3'd0 || axi.AWVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done got dones=%0d lvl=%0d awv=%b exp 1 0 0", dones, fifo_level, axi.AWVALID);
        end
    endtask

    task automatic test_split_handshake();
        logic [2:0] exp_v;
        hard_reset(1'b0);
        cmd_addr = 4'h3; cmd_data = 7'h55; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int c = 1; c <= 8; c++) begin
            axi.AWREADY = (c == 3);
            axi.WREADY  = (c == 6);
            tick();
            exp_v = {c < 3, c < 6, c >= 6};
            n_tests++;
            if ({axi.AWVALID, axi.WVALID, axi.BREADY} !== exp_v) begin
                n_fail++;
                $display("FAIL split_c%0d got awv/wv/brdy=%b exp %b", c, {axi.AWVALID, axi.WVALID, axi.BREADY}, exp_v);
            end
        end
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b1;
        tick();
        axi.BVALID = 1'b0;
        n_tests++;
        if ({wr_done, axi.BREADY} !== 2'b10) begin
            n_fail++;
            $display("FAIL split_resp got done=%b brdy=%b exp 1 0", wr_done, axi.BREADY);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ca [6];
        logic [6:0] cd [6];
        int idx = 0, hs_i = 0, dones = 0, cyc = 0;
        logic acc;
        hard_reset(1'b0);
        for (int i = 0; i < 6; i++) begin
            ca[i] = 4'($urandom);
            cd[i] = 7'($urandom);
        end
        for (int c = 0; c < 10; c++) begin
            cmd_valid = (idx < 6);
            cmd_addr = ca[idx % 6]; cmd_data = cd[idx % 6];
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) idx++;
        end
        n_tests++;
        if (idx != 5 || fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_holdoff got accepted=%0d lvl=%0d rdy=%b exp 5 4 0", idx, fifo_level, cmd_ready);
        end
        axi.AWREADY = 1'b1; axi.WREADY = 1'b1; axi.BVALID = 1'b1;
        while (dones < 6 && cyc < 80) begin
            cmd_valid = (idx < 6);
            cmd_addr = ca[idx % 6]; cmd_data = cd[idx % 6];
            acc = cmd_valid && cmd_ready;
            if (axi.AWVALID && axi.AWREADY) begin
                n_tests++;
                if ({axi.AWADDR, axi.WDATA} !== {ca[hs_i % 6], cd[hs_i % 6]}) begin
                    n_fail++;
                    $display("FAIL order_%0d got %h/%h exp %h/%h", hs_i, axi.AWADDR, axi.WDATA, ca[hs_i % 6], cd[hs_i % 6]);
                end
                hs_i++;
            end
            tick();
            cyc++;
            if (acc) idx++;
            dones += int'(wr_done);
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (dones != 6 || hs_i != 6) begin
            n_fail++;
            $display("FAIL drain_count got dones=%0d handshakes=%0d exp 6 6", dones, hs_i);
        end
    endtask

    task automatic test_early_bvalid();
        hard_reset(1'b1);
        cmd_addr = 4'hC; cmd_data = 7'h11; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++;
            if ({axi.BREADY, wr_done} !== 2'b00) begin
                n_fail++;
                $display("FAIL early_b_%0d got brdy=%b done=%b exp 0 0", c, axi.BREADY, wr_done);
            end
        end
        axi.AWREADY = 1'b1;
        tick();
        axi.AWREADY = 1'b0;
        n_tests++;
        if ({axi.AWVALID, axi.BREADY} !== 2'b00) begin
            n_fail++;
            $display("FAIL early_b_aw got awv=%b brdy=%b exp 0 0", axi.AWVALID, axi.BREADY);
        end
        axi.WREADY = 1'b1;
        tick();
        axi.WREADY = 1'b0;
        n_tests++;
        if ({axi.BREADY, wr_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL early_b_w got brdy=%b done=%b exp 1 0", axi.BREADY, wr_done);
        end
        tick();
        n_tests++;
        if (wr_done !== 1'b1) begin
            n_fail++;
            $display("FAIL early_b_done got %b exp 1", wr_done);
        end
        axi.BVALID = 1'b0;
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        hard_reset(1'b0);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_addr = 4'(i + 1); cmd_data = 7'(i + 7);
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        n_tests++;
        if ({axi.AWVALID, fifo_level} !== {1'b1, 3'd2}) begin
            n_fail++;
            $display("FAIL mid_pre got awv=%b lvl=%0d exp 1 2", axi.AWVALID, fifo_level);
        end
        ARESETn = 1'b0;
        #1;
        n_tests++;
        if ({axi.AWVALID, axi.WVALID, fifo_level, wr_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_reset got awv=%b wv=%b lvl=%0d done=%b exp all 0", axi.AWVALID, axi.WVALID, fifo_level, wr_done);
        end
        #2;
        ARESETn = 1'b1;
        axi.AWREADY = 1'b1; axi.WREADY = 1'b1; axi.BVALID = 1'b1;
        repeat (8) begin
            tick();
            stray += int'(axi.AWVALID) + int'(wr_done);
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL mid_after got %0d stray valid/done cycles exp 0", stray);
        end
    endtask

`ifdef AUDIO_WR_TIMEOUT_EN
    task automatic test_timeout();
        int to_at = -1;
        logic [4:0] relaunch = '0;
        hard_reset(1'b0);
        axi.WREADY = 1'b1;
        cmd_valid = 1'b1; cmd_addr = 4'h1; cmd_data = 7'h01;
        tick();
        cmd_addr = 4'hB; cmd_data = 7'h3C;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (wr_timeout && to_at < 0) to_at = c;
            if (c == 9) relaunch = {axi.AWVALID, axi.AWADDR};
        end
        n_tests++;
        if (to_at != 8 || relaunch !== {1'b1, 4'hB}) begin
            n_fail++;
            $display("FAIL timeout got pulse_at=%0d relaunch=%h exp 8 1b", to_at, relaunch);
        end
        axi.WREADY = 1'b0;
    endtask
`endif

    task automatic test_random(input int n_cmd);
        logic [3:0] qa [$];
        logic [6:0] qd [$];
        int acc = 0, launched = 0, aw_i = 0, w_i = 0, b_i = 0, cyc = 0;
        logic aw_hs, w_hs, b_hs, push, prev_awv, exp_rdy;
        logic [3:0] na;
        logic [6:0] nd;
        logic [2:0] exp_lvl;
        hard_reset(1'b0);
        na = 4'($urandom); nd = 7'($urandom);
        while (b_i < n_cmd && cyc < 4000) begin
            cmd_valid   = (acc < n_cmd) && ($urandom_range(0, 9) < 6);
            cmd_addr    = na; cmd_data = nd;
            axi.AWREADY = ($urandom_range(0, 9) < 8);
            axi.WREADY  = ($urandom_range(0, 9) < 8);
            axi.BVALID  = ($urandom_range(0, 9) < 8);
            push  = cmd_valid && cmd_ready;
            aw_hs = axi.AWVALID && axi.AWREADY;
            w_hs  = axi.WVALID && axi.WREADY;
            b_hs  = axi.BVALID && axi.BREADY;
            if (b_hs) begin
                n_tests++;
                if (aw_i != b_i + 1 || w_i != b_i + 1) begin
                    n_fail++;
                    $display("FAIL rnd_b_early got aw=%0d w=%0d at resp %0d exp both %0d", aw_i, w_i, b_i, b_i + 1);
                end
            end
            if (aw_hs) begin
                n_tests++;
                if (aw_i >= qa.size() || axi.AWADDR !== qa[aw_i]) begin
                    n_fail++;
                    $display("FAIL rnd_awaddr_%0d got %h exp %h", aw_i, axi.AWADDR, qa[aw_i]);
                end
                aw_i++;
            end
            if (w_hs) begin
                n_tests++;
                if (w_i >= qd.size() || axi.WDATA !== qd[w_i]) begin
                    n_fail++;
                    $display("FAIL rnd_wdata_%0d got %h exp %h", w_i, axi.WDATA, qd[w_i]);
                end
                w_i++;
            end
            prev_awv = axi.AWVALID;
            tick();
            cyc++;
            if (push) begin
                qa.push_back(na); qd.push_back(nd); acc++;
                na = 4'($urandom); nd = 7'($urandom);
            end
            if (axi.AWVALID && !prev_awv) launched++;
            if (b_hs) b_i++;
            exp_lvl = 3'(acc - launched);
            exp_rdy = (exp_lvl != 3'd4);
            n_tests++;
            if ({wr_done, wr_timeout, fifo_level, cmd_ready} !== {b_hs, 1'b0, exp_lvl, exp_rdy}) begin
                n_fail++;
                $display("FAIL rnd_cyc%0d got done=%b to=%b lvl=%0d rdy=%b exp %b 0 %0d %b",
                         cyc, wr_done, wr_timeout, fifo_level, cmd_ready, b_hs, exp_lvl, exp_rdy);
            end
        end
        cmd_valid = 1'b0; axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0;
        n_tests++;
        if (b_i != n_cmd || aw_i != n_cmd || w_i != n_cmd) begin
            n_fail++;
            $display("FAIL rnd_complete got b=%0d aw=%0d w=%0d exp %0d", b_i, aw_i, w_i, n_cmd);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_split_handshake();
        test_back_to_back();
        test_early_bvalid();
        test_reset_mid();
        test_random(40);
`ifdef AUDIO_WR_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
